hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit with HI/LO registers for the EX stage of the pipelined MIPS core.
//  Next generation of the EX-stage mul/div: generic width, configurable latencies, MADD/MSUB accumulate, flush, divide-by-zero flag.
//  Sits beside the ALU; operands arrive already forwarded; busy feeds the hazard unit, which stalls MF*/MT*/mul/div while busy.
// PARAMETERS
//  WIDTH       32  operand and HI/LO width
//  MUL_CYCLES  5   cycles from accepted start to HI/LO update, all multiply ops (>=1)
//  DIV_CYCLES  10  cycles from accepted start to HI/LO update, divide ops (>=1)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-low reset (reset==0 at a clk edge resets)
//  start      in   1      launch op; sampled only when busy==0
//  op         in   4      0 MULT,1 MULTU,2 DIV,3 DIVU,4 MADD,5 MADDU,6 MSUB,7 MSUBU,8 MTHI,9 MTLO; others = no-op
//  d1         in   WIDTH  operand A (rs), or MTHI/MTLO write data
//  d2         in   WIDTH  operand B (rt)
//  flush      in   1      abort in-flight op (EX flush on exception/branch)
//  busy       out  1      operation in flight
//  done       out  1      one-cycle pulse: HI/LO just updated by mul/div
//  div_zero   out  1      one-cycle pulse with done: divisor was zero
//  hi         out  WIDTH  HI register
//  lo         out  WIDTH  LO register
// BEHAVIOUR
//  Reset: hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0, latched operands cleared. Reset wins over every input.
//  Accept: start=1, busy=0, op in 0..7 at edge t -> latch op/d1/d2 (and {hi,lo} snapshot for MADD/MSUB);
//   counter<=MUL_CYCLES or DIV_CYCLES; busy=1 from after edge t until edge t+N, where the result is written to HI/LO and done=1 for that cycle.
//  busy = (counter!=0), registered; new start accepted on the cycle done is high (back-to-back allowed).
//  start while busy=1: ignored, no state change (hazard unit is required to stall it).
//  MTHI/MTLO: when busy=0, write d1 to hi/lo at that edge; no busy, no done. Ignored while busy.
//  flush=1: counter<=0, busy<=0, no HI/LO write, no done; flush beats a same-cycle start; flush while idle has no effect.
//  flush on the same edge as completion (counter==1): flush wins, result discarded.
//  Arithmetic:
//   MULT/MULTU: {hi,lo} = signed/unsigned 2*WIDTH product.
//   MADD(U)/MSUB(U): {hi,lo} = snapshot +/- product, modulo 2^(2*WIDTH); the snapshot is taken at accept.
//   DIV/DIVU: lo=quotient, hi=remainder; signed quotient truncates toward zero, remainder takes the dividend's sign.
//   Signed MIN/-1: lo=MIN, hi=0, no flag.
//   Divisor 0: hi/lo unchanged, done=1 and div_zero=1 at completion, full DIV_CYCLES latency.
//  Computation may be done at accept and held for the latency; only the timing of visible HI/LO is specified.
//  hi/lo are direct register outputs; MFHI/MFLO select happens outside this block.
// STRUCTURE
//  Shared package/header: op encodings (OP_MULT..OP_MTLO), default latencies.
//  One sub-module, muldiv_core: pure combinational signed/unsigned product and quotient/remainder of WIDTH operands.
//  Top holds the FSM (IDLE/RUN as counter!=0), operand/snapshot latches and HI/LO.
// TESTING
//  1 Reset held low 2 cycles with start=1 -> hi=lo=0, busy=0; release, MULT 3,-2 -> after 5 edges {hi,lo}=64'hFFFFFFFF_FFFFFFFA, done pulse.
//  2 MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001; busy high exactly 5 cycles; a 2nd start mid-run is ignored.
//  3 DIV -7,2 -> lo=FFFFFFFD, hi=FFFFFFFF after 10 edges; DIV 80000000,FFFFFFFF -> lo=80000000, hi=0.
//  4 MTHI 1, MTLO 2, DIVU 5,0 -> done=div_zero=1 at edge 10; hi=1, lo=2 unchanged.
//  5 hi=0,lo=10; MADDU 3,4 -> lo=22; MSUB 5,5 -> {hi,lo}=64'hFFFFFFFF_FFFFFFFD (wrap).
//  6 MULT 2,2 then flush on the 3rd busy cycle -> busy=0 next cycle, hi/lo unchanged, no done; flush+start same edge -> not accepted.

Source files
------------

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage HI/LO multiply/divide unit.
// Op encodings, default latencies and small op-class helpers.
package hilo_muldiv_unit_pkg;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MADD  = 4'd4,
        OP_MADDU = 4'd5,
        OP_MSUB  = 4'd6,
        OP_MSUBU = 4'd7,
        OP_MTHI  = 4'd8,
        OP_MTLO  = 4'd9
    } op_e;

    localparam int DEF_MUL_CYCLES = 5;
    localparam int DEF_DIV_CYCLES = 10;

    function automatic logic is_arith(input logic [3:0] op);
        return !op[3];
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_core.sv
// Combinational signed/unsigned product and quotient/remainder.
// Division works on magnitudes so MIN/-1 wraps to MIN with a zero remainder.
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sgn,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   quot,
    output logic [WIDTH-1:0]   rem
);

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;

    always_comb begin
        a_neg = sgn & a[WIDTH-1];
        b_neg = sgn & b[WIDTH-1];
        a_ext = {{WIDTH{a_neg}}, a};
        b_ext = {{WIDTH{b_neg}}, b};
        prod  = a_ext * b_ext;
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
        q_mag = '0;
        r_mag = '0;
        if (b_mag != '0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem  = a_neg ? -r_mag : r_mag;
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Operands are latched at accept; the result is written after the op latency.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e             state;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_d, lo_d;
    logic               done_d, dz_d;
    logic               sgn;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    assign state = (cnt_q != '0) ? S_RUN : S_IDLE;
    assign busy  = (state == S_RUN);
    assign sgn   = ~op_q[0];

    muldiv_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a   (a_q),
        .b   (b_q),
        .sgn (sgn),
        .prod(prod),
        .quot(quot),
        .rem (rem)
    );

    always_comb begin
        case (op_q)
            OP_MADD, OP_MADDU: mul_res = acc_q + prod;
            OP_MSUB, OP_MSUBU: mul_res = acc_q - prod;
            default:           mul_res = prod;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        hi_d   = hi;
        lo_d   = lo;
        done_d = 1'b0;
        dz_d   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start && !flush) begin
                    unique case (1'b1)
                        is_arith(op): begin
                            op_d  = op;
                            a_d   = d1;
                            b_d   = d2;
                            acc_d = {hi, lo};
                            cnt_d = is_div(op) ? CW'(DIV_CYCLES)
                                               : CW'(MUL_CYCLES);
                        end
                        (op == OP_MTHI): hi_d = d1;
                        (op == OP_MTLO): lo_d = d1;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (flush) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        done_d = 1'b1;
                        if (!is_div(op_q)) begin
                            {hi_d, lo_d} = mul_res;
                        end else if (b_q == '0) begin
                            dz_d = 1'b1;
                        end else begin
                            hi_d = rem;
                            lo_d = quot;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            hi       <= hi_d;
            lo       <= lo_d;
            done     <= done_d;
            div_zero <= dz_d;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed cases plus random ops
// checked every cycle against an event-time arithmetic model.
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        flush;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    int          edge_n = 0;
    bit          m_pend = 0;
    int          m_done_edge = 0;
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;
    bit          m_done = 0;
    bit          m_dz = 0;
    logic [31:0] r_hi, r_lo;
    bit          r_dz;

    hilo_muldiv_unit #(
        .WIDTH(32),
        .MUL_CYCLES(5),
        .DIV_CYCLES(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .d1(d1),
        .d2(d2),
        .flush(flush),
        .busy(busy),
        .done(done),
        .div_zero(div_zero),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Result of an op from its operands and the HI/LO value at accept
    task automatic compute(input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p, acc;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        acc = {m_hi, m_lo};
        r_dz = 0;
        r_hi = m_hi;
        r_lo = m_lo;
        p = o[0] ? ua * ub : sa * sb;
        if (o == 2 || o == 3) begin
            if (b == 0) begin
                r_dz = 1;
            end else if (o == 2) begin
                p = sa / sb;
                r_lo = p[31:0];
                p = sa % sb;
                r_hi = p[31:0];
            end else begin
                p = ua / ub;
                r_lo = p[31:0];
                p = ua % ub;
                r_hi = p[31:0];
            end
        end else begin
            if (o == 4 || o == 5) p = acc + p;
            else if (o == 6 || o == 7) p = acc - p;
            r_hi = p[63:32];
            r_lo = p[31:0];
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic [3:0] o,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic f);
        m_done = 0;
        m_dz   = 0;
        if (!r) begin
            m_hi = 0;
            m_lo = 0;
            m_pend = 0;
        end else if (m_pend) begin
            if (f) begin
                m_pend = 0;
            end else if (edge_n == m_done_edge) begin
                m_pend = 0;
                m_done = 1;
                m_dz = r_dz;
                m_hi = r_hi;
                m_lo = r_lo;
            end
        end else if (s && !f) begin
            if (o <= 7) begin
                compute(o, a, b);
                m_pend = 1;
                m_done_edge = edge_n + ((o == 2 || o == 3) ? 10 : 5);
            end else if (o == 8) begin
                m_hi = a;
            end else if (o == 9) begin
                m_lo = a;
            end
        end
    endtask

    task automatic tick(input logic r, input logic s, input logic [3:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic f);
        reset = r;
        start = s;
        op    = o;
        d1    = a;
        d2    = b;
        flush = f;
        @(posedge clk);
        #1;
        edge_n++;
        model_edge(r, s, o, a, b, f);
        check("busy", busy, m_pend);
        check("done", done, m_done);
        check("div_zero", div_zero, m_dz);
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            4: return -$urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    int busy_cnt;

    initial begin
        reset = 0;
        start = 0;
        op = 0;
        d1 = 0;
        d2 = 0;
        flush = 0;

        tick(0, 1, 0, 32'd7, 32'd9, 0);
        tick(0, 1, 0, 32'd7, 32'd9, 0);
        check("rst_hilo", {hi, lo}, 64'h0);
        check("rst_busy", busy, 1'b0);
        tick(1, 1, 0, 32'd3, -32'd2, 0);
        idle(5);
        check("mult_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        check("mult_done", done, 1'b1);

        tick(1, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        busy_cnt = busy ? 1 : 0;
        tick(1, 1, 0, 32'd2, 32'd2, 0);
        if (busy) busy_cnt++;
        for (int i = 0; i < 5; i++) begin
            tick(1, 0, 0, 0, 0, 0);
            if (busy) busy_cnt++;
        end
        check("multu_busy_len", busy_cnt, 5);
        check("multu_res", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        tick(1, 1, 2, -32'd7, 32'd2, 0);
        idle(10);
        check("div_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        tick(1, 1, 2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        idle(10);
        check("div_minneg1", {hi, lo}, 64'h0000_0000_8000_0000);
        check("div_minneg1_dz", div_zero, 1'b0);

        tick(1, 1, 8, 32'd1, 0, 0);
        tick(1, 1, 9, 32'd2, 0, 0);
        tick(1, 1, 3, 32'd5, 32'd0, 0);
        idle(9);
        check("dz_early", done, 1'b0);
        idle(1);
        check("dz_done", done, 1'b1);
        check("dz_flag", div_zero, 1'b1);
        check("dz_hilo", {hi, lo}, 64'h0000_0001_0000_0002);

        tick(1, 1, 8, 32'd0, 0, 0);
        tick(1, 1, 9, 32'd10, 0, 0);
        tick(1, 1, 5, 32'd3, 32'd4, 0);
        idle(5);
        check("maddu_res", {hi, lo}, 64'h0000_0000_0000_0016);
        tick(1, 1, 6, 32'd5, 32'd5, 0);
        idle(5);
        check("msub_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        tick(1, 1, 0, 32'd2, 32'd2, 0);
        idle(2);
        tick(1, 0, 0, 0, 0, 1);
        check("flush_busy", busy, 1'b0);
        idle(6);
        check("flush_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        tick(1, 1, 0, 32'd7, 32'd7, 1);
        check("flush_start", busy, 1'b0);
        idle(6);
        check("flush_start_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 199) != 0,
                 $urandom_range(0, 2) != 0,
                 4'($urandom_range(0, 11)),
                 pick(), pick(),
                 $urandom_range(0, 23) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
